// File: rtl/approx_adder_pipe.sv
// Pipelined approximate adder with a per-transaction mode and imprecise-part width k.
// Handshakes on both sides use valid/ready; one or two register stages.
module approx_adder_pipe #(
    parameter int ADDER_LENGTH  = 32,
    parameter int IMPRECISE_MAX = 16,
    parameter int PIPE_STAGES   = 2,
    localparam int KW = $clog2(IMPRECISE_MAX + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [ADDER_LENGTH-1:0] a,
    input  logic [ADDER_LENGTH-1:0] b,
    input  logic [1:0]              mode,
    input  logic [KW-1:0]           imp_bits,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDER_LENGTH:0]   sum,
    output logic [1:0]              out_mode
);

    localparam int N = ADDER_LENGTH;
    localparam logic [KW-1:0] KMAX = KW'(IMPRECISE_MAX);
    localparam logic [N-1:0]  ONE  = N'(1);

    logic [KW-1:0] k_clamp;
    logic [KW-1:0] k_eff;
    logic [N-1:0]  lmask;
    logic [N-1:0]  msb;
    logic [N-1:0]  lower;
    logic          carry;
    logic [N-1:0]  a_hi;
    logic [N-1:0]  b_hi;

    logic          out_valid_reg;
    logic [N:0]    sum_reg;
    logic [1:0]    out_mode_reg;

    // Upper part is exact over the operand bits above k, then placed back at bit k.
    function automatic logic [N:0] upper_sum(input logic [N-1:0] ah, input logic [N-1:0] bh,
                                             input logic c, input logic [KW-1:0] kk);
        logic [N:0] t;
        t = {1'b0, ah} + {1'b0, bh} + {{N{1'b0}}, c};
        return t << kk;
    endfunction

    // Exact mode is expressed as k=0, so one datapath serves all four modes.
    always_comb begin
        k_clamp = (imp_bits > KMAX) ? KMAX : imp_bits;
        k_eff   = (mode == 2'd0) ? '0 : k_clamp;
        lmask   = (ONE << k_eff) - ONE;
        msb     = (k_eff == '0) ? '0 : (ONE << (k_eff - 1'b1));
        a_hi    = a >> k_eff;
        b_hi    = b >> k_eff;
        lower   = '0;
        carry   = 1'b0;
        case (mode)
            2'd1: begin
                lower = b & lmask;
                carry = |(a & msb);
            end
            2'd2: begin
                lower = (a | b) & lmask;
                carry = (|(a & msb)) & (|(b & msb));
            end
            default: begin
                lower = '0;
                carry = 1'b0;
            end
        endcase
    end

    generate
        if (PIPE_STAGES == 1) begin : g_one
            logic adv;
            assign adv      = !out_valid_reg || out_ready;
            assign in_ready = adv;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid_reg <= 1'b0;
                    sum_reg       <= '0;
                    out_mode_reg  <= '0;
                end else if (adv) begin
                    out_valid_reg <= in_valid;
                    if (in_valid) begin
                        sum_reg      <= upper_sum(a_hi, b_hi, carry, k_eff) | {1'b0, lower};
                        out_mode_reg <= mode;
                    end
                end
            end
        end else begin : g_two
            logic          v1_reg;
            logic [N-1:0]  s1_lower_reg;
            logic          s1_carry_reg;
            logic [N-1:0]  s1_ahi_reg;
            logic [N-1:0]  s1_bhi_reg;
            logic [KW-1:0] s1_k_reg;
            logic [1:0]    s1_mode_reg;
            logic          adv2;
            logic          load1;

            assign adv2     = !out_valid_reg || out_ready;
            assign in_ready = !v1_reg || adv2;
            assign load1    = in_valid && in_ready;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1_reg        <= 1'b0;
                    s1_lower_reg  <= '0;
                    s1_carry_reg  <= 1'b0;
                    s1_ahi_reg    <= '0;
                    s1_bhi_reg    <= '0;
                    s1_k_reg      <= '0;
                    s1_mode_reg   <= '0;
                    out_valid_reg <= 1'b0;
                    sum_reg       <= '0;
                    out_mode_reg  <= '0;
                end else begin
                    if (load1) begin
                        v1_reg       <= 1'b1;
                        s1_lower_reg <= lower;
                        s1_carry_reg <= carry;
                        s1_ahi_reg   <= a_hi;
                        s1_bhi_reg   <= b_hi;
                        s1_k_reg     <= k_eff;
                        s1_mode_reg  <= mode;
                    end else if (adv2) begin
                        v1_reg <= 1'b0;
                    end
                    if (adv2) begin
                        out_valid_reg <= v1_reg;
                        if (v1_reg) begin
                            sum_reg      <= upper_sum(s1_ahi_reg, s1_bhi_reg, s1_carry_reg, s1_k_reg)
                                            | {1'b0, s1_lower_reg};
                            out_mode_reg <= s1_mode_reg;
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid = out_valid_reg;
    assign sum       = sum_reg;
    assign out_mode  = out_mode_reg;

endmodule

// File: tb/tb_approx_adder_pipe.sv
// Scoreboard bench for approx_adder_pipe (8-bit operands, k up to 4, two stages).
// The reference model works on integers with division/modulo by 2^k.
module tb_approx_adder_pipe;

    localparam int N    = 8;
    localparam int IMAX = 4;
    localparam int KW   = $clog2(IMAX + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic [1:0]    mode = '0;
    logic [KW-1:0] imp_bits = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [N:0]    sum;
    logic [1:0]    out_mode;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int acc_cnt = 0;
    int last_acc_cyc = 0;
    int rnd_bp = 0;
    int sb_sum[$];
    int sb_mode[$];
    int out_cycs[$];

    approx_adder_pipe #(.ADDER_LENGTH(N), .IMPRECISE_MAX(IMAX), .PIPE_STAGES(2)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .mode(mode), .imp_bits(imp_bits),
        .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .out_mode(out_mode)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int model(input int av, input int bv, input int m, input int kb);
        int k, p, la, lb, lower, carry;
        k = (kb > IMAX) ? IMAX : kb;
        if (m == 0 || k == 0) return av + bv;
        p  = 1 << k;
        la = av % p;
        lb = bv % p;
        case (m)
            1: begin lower = lb; carry = (la >= p / 2) ? 1 : 0; end
            2: begin lower = la | lb; carry = (la >= p / 2 && lb >= p / 2) ? 1 : 0; end
            default: begin lower = 0; carry = 0; end
        endcase
        return (av / p + bv / p + carry) * p + lower;
    endfunction

    // Monitor: checks completions and result stability while stalled.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb_sum.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else if (out_ready) begin
                chk("sum", int'(sum), sb_sum[0]);
                chk("out_mode", int'(out_mode), sb_mode[0]);
                $display("result sum=0x%03h mode=%0d cycle=%0d", sum, out_mode, cyc);
                void'(sb_sum.pop_front());
                void'(sb_mode.pop_front());
                out_cycs.push_back(cyc);
            end else begin
                chk("held_sum", int'(sum), sb_sum[0]);
            end
        end
    end

    always @(posedge clk) begin
        if (rnd_bp != 0) begin
            #1 out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send(input int av, input int bv, input int m, input int kb);
        bit ok;
        ok = 0;
        a = N'(av); b = N'(bv); mode = 2'(m); imp_bits = KW'(kb);
        in_valid = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb_sum.push_back(model(av, bv, m, kb));
                sb_mode.push_back(m);
                acc_cnt++;
                last_acc_cyc = cyc;
                $display("accept a=0x%02h b=0x%02h mode=%0d k=%0d cycle=%0d", av, bv, m, kb, cyc);
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        // Scramble inputs so the pipeline cannot depend on them after accept.
        a = N'($urandom); b = N'($urandom); mode = 2'($urandom); imp_bits = KW'($urandom);
    endtask

    task automatic drain();
        for (int t = 0; t < 300 && sb_sum.size() != 0; t++) @(negedge clk);
        chk("drain_empty", sb_sum.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_sum", int'(sum), 0);
        chk("rst_out_mode", int'(out_mode), 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk); #1;

        // 1: exact with carry out, latency 2
        out_cycs.delete();
        send(8'hFF, 8'h01, 0, 0);
        drain();
        chk("t1_latency", out_cycs[0] - last_acc_cyc, 2);

        // 2 and 3: directed approximate cases
        send(8'h3C, 8'h15, 1, 4);
        send(8'h3C, 8'h15, 2, 4);
        send(8'h3C, 8'h15, 3, 4);
        send(8'h3C, 8'h15, 1, 7);
        send(8'h3C, 8'h15, 3, 0);
        drain();

        // 4: back-to-back stream of 6, results on consecutive cycles
        out_cycs.delete();
        for (int i = 0; i < 6; i++) send($urandom_range(0, 255), $urandom_range(0, 255), i % 4, i % 5);
        drain();
        chk("t4_count", out_cycs.size(), 6);
        for (int i = 1; i < out_cycs.size(); i++) chk("t4_consecutive", out_cycs[i] - out_cycs[i-1], 1);

        // 5: stall with continuous input, fills to 2 then blocks
        out_ready = 1'b0;
        acc_cnt = 0;
        fork
            for (int i = 0; i < 4; i++) send($urandom_range(0, 255), $urandom_range(0, 255), 1 + i % 3, 1 + i % 4);
        join_none
        repeat (4) @(negedge clk);
        #1;
        chk("t5_accepts", acc_cnt, 2);
        chk("t5_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 out_ready = 1'b1;
        for (int t = 0; t < 100 && acc_cnt < 4; t++) @(negedge clk);
        chk("t5_all_accepted", acc_cnt, 4);
        wait fork;
        drain();

        // 6: reset with two transactions in flight
        out_ready = 1'b0;
        send(8'h11, 8'h22, 0, 0);
        send(8'h33, 8'h44, 2, 3);
        rst = 1'b1;
        #1;
        chk("t6_out_valid_in_rst", int'(out_valid), 0);
        sb_sum.delete();
        sb_mode.delete();
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        out_cycs.delete();
        repeat (5) @(negedge clk);
        chk("t6_no_stale", out_cycs.size(), 0);
        @(posedge clk); #1;
        send(8'h3C, 8'h15, 2, 4);
        drain();
        chk("t6_one_result", out_cycs.size(), 1);

        // Random traffic with random backpressure
        rnd_bp = 1;
        for (int i = 0; i < 150; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 3), $urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        rnd_bp = 0;
        @(posedge clk); #2 out_ready = 1'b1;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
